// File: rtl/calc_pkg.sv
// Shared types and constants for the DE10-Lite calculator sequencing controller.
package calc_pkg;

    localparam int OPW  = 4;
    localparam int RESW = 8;

    typedef enum logic [1:0] {
        MODE_ARITH   = 2'd0,
        MODE_LOGIC   = 2'd1,
        MODE_COMPARE = 2'd2,
        MODE_MAGIC   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    // MODE_MAGIC wraps back to MODE_ARITH through the natural 2-bit overflow.
    function automatic mode_e next_mode(input mode_e m);
        logic [1:0] w_m;
        w_m = m;
        return mode_e'(w_m + 2'd1);
    endfunction

endpackage

// File: rtl/calc_key_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce counter and press-pulse
// detector for one active-low key. The debounced level idles released (1).
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key,
    output logic o_level,
    output logic o_press
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_level_d;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // NOTE: every register here uses <= so the synchroniser stages and the
    // counter all see the pre-edge values, exactly like the flops they model.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_level   <= 1'b1;
            r_level_d <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_key;
            r_sync2   <= r_sync1;
            r_level_d <= r_level;
            r_press   <= r_level_d & ~r_level;
            // Count consecutive samples that disagree with the accepted level.
            if (r_sync2 != r_level) begin
                if (r_cnt == CNT_MAX) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/calc_controller.sv
// Calculator sequencing controller: debounced mode/execute keys, operand latch and
// start/done handshake. Optional WAIT timeout is enabled by CALC_CTRL_TIMEOUT_EN.
module calc_controller
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [1:0]      KEY,
    input  logic [9:0]      SW,
    input  logic            ALU_DONE,
    input  logic [RESW-1:0] ALU_RESULT,
    input  logic            ALU_OVF,
    output logic [1:0]      MODE,
    output logic [OPW-1:0]  X,
    output logic [OPW-1:0]  Y,
    output logic [1:0]      OPERATION,
    output logic            ALU_START,
    output logic [RESW-1:0] RESULT,
    output logic            OVF,
    output logic            RESULT_VALID,
    output logic            BUSY,
    output logic            ERR
);

    if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("calc_controller: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    logic w_mode_press;
    logic w_exec_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_key   (KEY[0]),
        .o_level (),
        .o_press (w_mode_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_exec (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_key   (KEY[1]),
        .o_level (),
        .o_press (w_exec_press)
    );

    // Switches are only sampled at the latch instant, so a plain 2-flop stage suffices.
    logic [9:0] r_sw_s1;
    logic [9:0] r_sw_s2;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= SW;
            r_sw_s2 <= r_sw_s1;
        end
    end

    state_e          r_state;
    mode_e           r_mode;
    logic [OPW-1:0]  r_x;
    logic [OPW-1:0]  r_y;
    logic [1:0]      r_op;
    logic            r_alu_start;
    logic [RESW-1:0] r_result;
    logic            r_ovf;
    logic            r_valid;
    logic            r_busy;
    logic            r_err;

`ifdef CALC_CTRL_TIMEOUT_EN
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCW-1:0] WAIT_MAX = TCW'(TIMEOUT_CYCLES - 1);
    logic [TCW-1:0] r_wait_cnt;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_mode      <= MODE_ARITH;
            r_x         <= '0;
            r_y         <= '0;
            r_op        <= '0;
            r_alu_start <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
`ifdef CALC_CTRL_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            r_alu_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Execute has priority; a simultaneous mode press is dropped.
                    if (w_exec_press) begin
                        r_x         <= r_sw_s2[3:0];
                        r_y         <= r_sw_s2[7:4];
                        r_op        <= r_sw_s2[9:8];
                        r_valid     <= 1'b0;
                        r_err       <= 1'b0;
                        r_alu_start <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_START;
                    end else if (w_mode_press) begin
                        r_mode <= next_mode(r_mode);
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
`ifdef CALC_CTRL_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                ST_WAIT: begin
                    if (ALU_DONE) begin
                        r_result <= ALU_RESULT;
                        r_ovf    <= ALU_OVF;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
`ifdef CALC_CTRL_TIMEOUT_EN
                    else if (r_wait_cnt == WAIT_MAX) begin
                        r_result <= '1;
                        r_ovf    <= 1'b0;
                        r_valid  <= 1'b0;
                        r_err    <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign MODE         = r_mode;
    assign X            = r_x;
    assign Y            = r_y;
    assign OPERATION    = r_op;
    assign ALU_START    = r_alu_start;
    assign RESULT       = r_result;
    assign OVF          = r_ovf;
    assign RESULT_VALID = r_valid;
    assign BUSY         = r_busy;
    assign ERR          = r_err;

endmodule

// File: tb/tb_calc_controller.sv
// Directed self-checking bench for calc_controller (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=16).
module tb_calc_controller;

    localparam int DB   = 4;
    localparam int HOLD = DB + 6;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic [1:0] KEY;
    logic [9:0] SW;
    logic       ALU_DONE;
    logic [7:0] ALU_RESULT;
    logic       ALU_OVF;
    logic [1:0] MODE;
    logic [3:0] X;
    logic [3:0] Y;
    logic [1:0] OPERATION;
    logic       ALU_START;
    logic [7:0] RESULT;
    logic       OVF;
    logic       RESULT_VALID;
    logic       BUSY;
    logic       ERR;

    int n_cmp = 0;
    int n_err = 0;
    int start_cnt = 0;

    calc_controller #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(16)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .KEY          (KEY),
        .SW           (SW),
        .ALU_DONE     (ALU_DONE),
        .ALU_RESULT   (ALU_RESULT),
        .ALU_OVF      (ALU_OVF),
        .MODE         (MODE),
        .X            (X),
        .Y            (Y),
        .OPERATION    (OPERATION),
        .ALU_START    (ALU_START),
        .RESULT       (RESULT),
        .OVF          (OVF),
        .RESULT_VALID (RESULT_VALID),
        .BUSY         (BUSY),
        .ERR          (ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (ALU_START) start_cnt <= start_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press_key(input int idx);
        KEY[idx] = 1'b0;
        step(HOLD);
        KEY[idx] = 1'b1;
        step(HOLD);
    endtask

    // Hold the selected key(s) low until ALU_START appears, bounded.
    task automatic exec_until_start(input string tag, input logic both);
        KEY[1] = 1'b0;
        if (both) KEY[0] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (ALU_START) break;
        end
        check(tag, ALU_START, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mode"},  MODE, 0);
        check({tag, "_xyop"},  {X, Y, OPERATION}, 0);
        check({tag, "_res"},   {RESULT, OVF, RESULT_VALID}, 0);
        check({tag, "_flags"}, {BUSY, ERR, ALU_START}, 0);
    endtask

    initial begin
        RST_N = 1'b0;
        KEY = 2'b11;
        SW = '0;
        ALU_DONE = 1'b0;
        ALU_RESULT = '0;
        ALU_OVF = 1'b0;
        step(3);
        check_all_zero("reset");
        RST_N = 1'b1;
        step(2);

        // Mode stepping and wrap, then a too-short glitch.
        press_key(0); check("mode_1", MODE, 2'd1);
        press_key(0); check("mode_2", MODE, 2'd2);
        press_key(0); check("mode_3", MODE, 2'd3);
        press_key(0); check("mode_wrap", MODE, 2'd0);
        KEY[0] = 1'b0;
        step(DB - 1);
        KEY[0] = 1'b1;
        step(HOLD);
        check("glitch", MODE, 2'd0);
        press_key(0); check("mode_again", MODE, 2'd1);

        // Basic operation: ALU_DONE five cycles after ALU_START.
        SW = 10'b01_0011_0101;
        step(3);
        exec_until_start("exec1_start", 1'b0);
        check("exec1_busy", BUSY, 1'b1);
        check("exec1_x", X, 4'd5);
        check("exec1_y", Y, 4'd3);
        check("exec1_op", OPERATION, 2'd1);
        check("exec1_valid_clr", RESULT_VALID, 1'b0);
        step(1);
        check("exec1_start_pulse", ALU_START, 1'b0);
        step(4);
        ALU_DONE = 1'b1;
        ALU_RESULT = 8'h08;
        ALU_OVF = 1'b0;
        step(1);
        ALU_DONE = 1'b0;
        check("exec1_result", RESULT, 8'h08);
        check("exec1_valid", RESULT_VALID, 1'b1);
        check("exec1_idle", BUSY, 1'b0);
        check("exec1_starts", start_cnt, 1);
        KEY[1] = 1'b1;
        step(HOLD);

`ifndef CALC_CTRL_TIMEOUT_EN
        // Both keys together, then mode/execute presses and SW changes during WAIT.
        exec_until_start("both_start", 1'b1);
        check("both_mode", MODE, 2'd1);
        KEY = 2'b11;
        step(HOLD);
        press_key(0);
        SW = 10'b10_1111_0000;
        press_key(1);
        check("wait_busy", BUSY, 1'b1);
        check("wait_starts", start_cnt, 2);
        check("wait_xyop", {X, Y, OPERATION}, {4'd5, 4'd3, 2'd1});
        ALU_DONE = 1'b1;
        ALU_RESULT = 8'hA5;
        ALU_OVF = 1'b1;
        step(1);
        ALU_DONE = 1'b0;
        check("both_result", {RESULT, OVF, RESULT_VALID}, {8'hA5, 1'b1, 1'b1});
        check("both_mode_after", MODE, 2'd1);
        step(HOLD);

        // Without the timeout, WAIT holds indefinitely.
        exec_until_start("hold_start", 1'b0);
        KEY[1] = 1'b1;
        step(40);
        check("hold_busy", BUSY, 1'b1);
        check("hold_err", ERR, 1'b0);
        check("hold_x", X, 4'd0);
`else
        exec_until_start("to_start", 1'b0);
        KEY[1] = 1'b1;
        step(16);
        check("to_busy_before", BUSY, 1'b1);
        step(1);
        check("to_busy_after", BUSY, 1'b0);
        check("to_err", ERR, 1'b1);
        check("to_result", {RESULT, OVF, RESULT_VALID}, {8'hFF, 1'b0, 1'b0});
        step(HOLD);
        exec_until_start("to2_start", 1'b0);
        KEY[1] = 1'b1;
        step(3);
`endif

        // Reset mid-WAIT for one cycle clears everything at once.
        RST_N = 1'b0;
        #1;
        check_all_zero("async_rst");
        step(1);
        RST_N = 1'b1;
        check_all_zero("post_rst");
        step(2);

        SW = 10'b11_1001_0110;
        step(3);
        exec_until_start("rst_exec_start", 1'b0);
        check("rst_exec_xyop", {X, Y, OPERATION}, {4'd6, 4'd9, 2'd3});
        step(2);
        ALU_DONE = 1'b1;
        ALU_RESULT = 8'h3C;
        ALU_OVF = 1'b0;
        step(1);
        ALU_DONE = 1'b0;
        KEY[1] = 1'b1;
        check("rst_exec_result", {RESULT, RESULT_VALID, BUSY}, {8'h3C, 1'b1, 1'b0});
        step(HOLD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/calc_controller.md
# calc_controller

Sequencing controller for the DE10-Lite calculator datapath. Debounces the two push-buttons and steps the 2-bit MODE that selects the arithmetic, logical, comparison or magic unit. On an execute press it captures the operands and the operation select from the switches, then runs a start/done handshake with the selected unit and holds the result for the display multiplexers. It replaces the purely combinational key-to-mode mapping, so multi-cycle units (e.g. a sequential divider) can share the display path.

## Interface
- DEBOUNCE_CYCLES, default 500000: stable samples required to accept a key level change (10 ms at 50 MHz).
- TIMEOUT_CYCLES, default 1024: maximum WAIT duration (only with the timeout feature compiled in).
- One clock; reset is asynchronous and active-low. CLK and RST_N are those ports.
- CLK  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- KEY  in  2  raw push-buttons, active-low, asynchronous. KEY[0] advances the mode; KEY[1] executes.
- SW  in  10  raw switches. [3:0] is X, [7:4] is Y, [9:8] is OPERATION.
- ALU_DONE  in  1  selected unit's result is valid this cycle.
- ALU_RESULT  in  8  selected unit's result.
- ALU_OVF  in  1  selected unit's overflow flag.
- MODE  out  2  unit select (0 arith, 1 logical, 2 compare, 3 magic).
- X  out  4  latched operand X.
- Y  out  4  latched operand Y.
- OPERATION  out  2  latched operation select.
- ALU_START  out  1  one-cycle start pulse.
- RESULT  out  8  captured result.
- OVF  out  1  captured overflow.
- RESULT_VALID  out  1  RESULT is current; sticky.
- BUSY  out  1  handshake in progress.
- ERR  out  1  last operation timed out.

## Operation
- Each KEY bit goes through a 2-flop synchroniser, then a debounce counter. The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples. A falling edge of the debounced level produces a one-cycle press pulse.
- Mode press while IDLE: MODE increments modulo 4 (3 wraps to 0). A mode press while BUSY is dropped, not queued.
- FSM states: IDLE, START, WAIT.
  - IDLE, on an execute press: latch X, Y and OPERATION from the synchronised SW, clear RESULT_VALID and ERR, then go to START.
  - START: ALU_START=1 for exactly one cycle, then go to WAIT. ALU_DONE is ignored in START.
  - WAIT, on ALU_DONE: RESULT<=ALU_RESULT, OVF<=ALU_OVF, RESULT_VALID<=1, go to IDLE.
- BUSY=1 in START and WAIT.
- An execute press while BUSY is dropped.
- Execute and mode pressed in the same IDLE cycle: the execute is taken and the mode press is dropped. MODE is therefore stable for the whole operation.
- X, Y and OPERATION stay constant from the latch until the next execute. SW changes do not reach the datapath mid-operation.
- Reset, including mid-operation: FSM goes to IDLE. MODE, X, Y, OPERATION, RESULT, OVF, RESULT_VALID, BUSY, ERR and ALU_START are all 0. Debounced key levels reset to released (1).

## Timing
- A key held low from edge t produces its press pulse at edge t+2+DEBOUNCE_CYCLES and no earlier.
- A new press requires release to be debounced first (DEBOUNCE_CYCLES high samples).
- Execute press at cycle c gives START at c+1 and WAIT from c+2.
- ALU_DONE at cycle d (d≥c+2) gives RESULT, OVF and RESULT_VALID updated at d+1, with BUSY low at d+1.
- Minimum execute-to-valid latency is 3 cycles.
- MODE updates one cycle after a mode press pulse.

## Configuration
- CALC_CTRL_TIMEOUT_EN defined:
  - A WAIT cycle counter runs. If it reaches TIMEOUT_CYCLES without ALU_DONE, the FSM returns to IDLE with ERR=1, RESULT=8'hFF, OVF=0 and RESULT_VALID=0.
  - ALU_DONE on the same cycle the counter expires wins.
- Not defined: no counter. WAIT holds indefinitely until ALU_DONE or reset, and ERR stays 0.

## Structure
- Shared package calc_pkg:
  - MODE encodings MODE_ARITH, MODE_LOGIC, MODE_COMPARE, MODE_MAGIC.
  - FSM state enum.
  - Width constants OPW=4 and RESW=8.
- Sub-module key_debounce, instantiated twice. It contains the synchroniser, the debounce counter and the press-pulse edge detector, and takes DEBOUNCE_CYCLES as a parameter.
- Bench builds use a small DEBOUNCE_CYCLES (e.g. 4).

## Test plan
- Reset mid-WAIT (RST_N low for 1 cycle) -> all outputs 0 immediately, and the FSM accepts a new execute after release.
- Four clean KEY[0] presses, DEBOUNCE_CYCLES=4 -> MODE steps 1, 2, 3, 0. A glitch of 3 cycles low produces no change.
- SW=10'b01_0011_0101, execute press, ALU_DONE 5 cycles after ALU_START with ALU_RESULT=8'h08 -> X=5, Y=3, OPERATION=1, a single ALU_START pulse, RESULT=8'h08 and RESULT_VALID=1.
- Both keys pressed on the same cycle in IDLE -> operation runs and MODE is unchanged. A mode press during WAIT leaves MODE unchanged after completion.
- SW toggled during WAIT -> X, Y and OPERATION hold their latched values. A second execute during WAIT produces no second ALU_START.
- CALC_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, ALU_DONE never asserted -> ERR=1, RESULT=8'hFF, BUSY=0 after 16 WAIT cycles. Without the macro, BUSY stays 1.
